// File: rtl/fp16_pkg.sv
// Shared FP16 types, constants and the exact FP16-to-fixed-point decoder.
// Fixed format is 18 integer bits (including sign) and 24 fractional bits.
package fp16_pkg;

  typedef logic [15:0] fp16_t;

  localparam int FIX_FRAC_W = 24;
  localparam int FIX_INT_W  = 18;
  localparam int FIX_W      = FIX_INT_W + FIX_FRAC_W;
  localparam int MAG_W      = FIX_W - 1;

  typedef logic signed [FIX_W-1:0] fixed42_t;

  localparam int    FP16_EXP_BIAS   = 15;
  localparam fp16_t FP16_QNAN       = 16'h7E00;
  localparam fp16_t FP16_POS_INF    = 16'h7C00;
  localparam fp16_t FP16_MAX_FINITE = 16'h7BFF;

  typedef enum logic [1:0] {
    SPC_NONE,
    SPC_NAN,
    SPC_INF
  } special_e;

  // One LSB of the fixed format is 2^-24, so every finite FP16 value decodes exactly.
  function automatic fixed42_t fp16_to_fixed(input fp16_t x);
    logic [FIX_W-1:0] mag;
    if (x[14:10] == 5'd0)
      mag = {{(FIX_W-10){1'b0}}, x[9:0]};
    else
      mag = {{(FIX_W-11){1'b0}}, 1'b1, x[9:0]} << (x[14:10] - 5'd1);
    return x[15] ? -fixed42_t'(mag) : fixed42_t'(mag);
  endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Combinational fixed-point magnitude + sign to FP16, round-to-nearest-even.
// With SUBFP16_SAT_EN defined, overflow saturates to max finite instead of inf.
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic             sign,
  input  logic [MAG_W-1:0] mag,
  output fp16_t            result,
  output logic             ovf
);

  localparam logic [MAG_W:0] EXT_ONE = {{MAG_W{1'b0}}, 1'b1};

  logic [5:0]     p;
  logic [5:0]     rsh;
  logic [MAG_W:0] ext;
  logic [MAG_W:0] mask;
  logic [10:0]    top;
  logic [4:0]     e;
  logic           guard;
  logic           sticky;
  logic           up;
  logic [15:0]    rounded;
  logic           ovf_c;

  always_comb begin
    p = '0;
    for (int i = 0; i < MAG_W; i++)
      if (mag[i]) p = 6'(i);
  end

  // A zero guard bit is appended so p=10 (exact, exponent 1) needs no special case.
  always_comb begin
    rsh     = (p >= 6'd10) ? p - 6'd10 : 6'd0;
    ext     = {mag, 1'b0};
    top     = ext[rsh +: 11];
    mask    = (EXT_ONE << rsh) - EXT_ONE;
    guard   = top[0];
    sticky  = |(ext & mask);
    up      = guard && (sticky || top[1]);
    e       = 5'(p - 6'd9);
    rounded = {1'b0, e, top[10:1]} + {15'd0, up};
    ovf_c   = rounded[15:10] >= 6'd31;
  end

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    if (p < 6'd10) begin
      result = {sign, 5'd0, mag[9:0]};
    end else if (ovf_c) begin
      ovf = 1'b1;
`ifdef SUBFP16_SAT_EN
      result = {sign, FP16_MAX_FINITE[14:0]};
`else
      result = {sign, FP16_POS_INF[14:0]};
`endif
    end else begin
      result = {sign, rounded[14:0]};
    end
  end

endmodule

// File: rtl/subfp16_pipe.sv
// Three-stage valid/ready FP16 subtractor: decode to fixed, subtract, round/pack.
// Optional SUBFP16_SAT_EN (in fp16_round_pack) saturates overflow to max finite.
module subfp16_pipe
  import fp16_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  fp16_t a,
  input  fp16_t b,
  output logic  out_valid,
  input  logic  out_ready,
  output fp16_t diff,
  output logic  out_ovf
);

  logic             adv;
  logic             a_nan, b_nan, a_inf, b_inf;
  logic             v1, v2;
  fixed42_t         fa1, fb1;
  special_e         spc1, spc2;
  logic             spc_sign1, spc_sign2;
  logic             zneg1;
  fixed42_t         d;
  logic             sign2;
  logic [MAG_W-1:0] mag2;
  fp16_t            rp_result;
  logic             rp_ovf;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign d        = fa1 - fb1;

  always_comb begin
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
  end

  fp16_round_pack u_round_pack (
    .sign   (sign2),
    .mag    (mag2),
    .result (rp_result),
    .ovf    (rp_ovf)
  );

  // Only (-0)-(+0) yields a negative zero; every other exact cancellation is +0.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      diff      <= '0;
      out_ovf   <= 1'b0;
      fa1       <= '0;
      fb1       <= '0;
      spc1      <= SPC_NONE;
      spc2      <= SPC_NONE;
      spc_sign1 <= 1'b0;
      spc_sign2 <= 1'b0;
      zneg1     <= 1'b0;
      sign2     <= 1'b0;
      mag2      <= '0;
    end else if (adv) begin
      v1  <= in_valid;
      fa1 <= fp16_to_fixed(a);
      fb1 <= fp16_to_fixed(b);
      if (a_nan || b_nan || (a_inf && b_inf && (a[15] == b[15])))
        spc1 <= SPC_NAN;
      else if (a_inf || b_inf)
        spc1 <= SPC_INF;
      else
        spc1 <= SPC_NONE;
      spc_sign1 <= a_inf ? a[15] : !b[15];
      zneg1     <= (a == 16'h8000) && (b == 16'h0000);

      v2        <= v1;
      sign2     <= d[FIX_W-1] || ((d == '0) && zneg1);
      mag2      <= d[FIX_W-1] ? MAG_W'(-d) : d[MAG_W-1:0];
      spc2      <= spc1;
      spc_sign2 <= spc_sign1;

      out_valid <= v2;
      if (v2) begin
        case (spc2)
          SPC_NAN: begin
            diff    <= FP16_QNAN;
            out_ovf <= 1'b0;
          end
          SPC_INF: begin
            diff    <= {spc_sign2, FP16_POS_INF[14:0]};
            out_ovf <= 1'b0;
          end
          default: begin
            diff    <= rp_result;
            out_ovf <= rp_ovf;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_subfp16_pipe.sv
// Self-checking bench for subfp16_pipe: directed vectors, stall/back-to-back,
// randomized stream against a real-arithmetic reference, and mid-flight reset.
module tb_subfp16_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        out_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  subfp16_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .out_ovf   (out_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16_val(input logic [15:0] x);
    int  e;
    int  m;
    real r;
    e = int'(x[14:10]);
    m = int'(x[9:0]);
    if (e == 0) r = real'(m) * pow2(-24);
    else        r = real'(m + 1024) * pow2(e - 25);
    return x[15] ? -r : r;
  endfunction

  // Reference: exact real difference, then IEEE round-to-nearest-even; returns {ovf, fp16}.
  function automatic logic [16:0] ref_sub(input logic [15:0] x, input logic [15:0] y);
    logic xn, yn, xi, yi, s;
    real  v, ax, sc, fr;
    int   e, ip;
    xn = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    yn = (y[14:10] == 5'h1F) && (y[9:0] != 10'd0);
    xi = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    yi = (y[14:10] == 5'h1F) && (y[9:0] == 10'd0);
    if (xn || yn || (xi && yi && (x[15] == y[15]))) return {1'b0, 16'h7E00};
    if (xi) return {1'b0, x[15], 15'h7C00};
    if (yi) return {1'b0, ~y[15], 15'h7C00};
    v = fp16_val(x) - fp16_val(y);
    if (v == 0.0) return ((x == 16'h8000) && (y == 16'h0000)) ? 17'h08000 : 17'h00000;
    s  = (v < 0.0);
    ax = s ? -v : v;
    if (ax < pow2(-14)) begin
      ip = $rtoi(ax * pow2(24));
      return {1'b0, s, 5'd0, ip[9:0]};
    end
    e = 0;
    while (ax >= 2.0) begin ax = ax / 2.0; e++; end
    while (ax < 1.0)  begin ax = ax * 2.0; e--; end
    sc = ax * 1024.0;
    ip = $rtoi(sc);
    fr = sc - real'(ip);
    if ((fr > 0.5) || ((fr == 0.5) && ip[0])) ip++;
    if (ip == 2048) begin ip = 1024; e++; end
    if (e > 15) begin
`ifdef SUBFP16_SAT_EN
      return {1'b1, s, 15'h7BFF};
`else
      return {1'b1, s, 15'h7C00};
`endif
    end
    ip = ip - 1024;
    e  = e + 15;
    return {1'b0, s, e[4:0], ip[9:0]};
  endfunction

  function automatic logic [15:0] rand_fp16();
    logic [15:0] x;
    x = 16'($urandom);
    case ($urandom_range(0, 7))
      0: x[14:10] = 5'h1F;
      1: x[14:10] = 5'h00;
      2: x[14:10] = 5'($urandom_range(28, 30));
      default: ;
    endcase
    return x;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (diff !== 16'h0000) begin bad++; $display("[TB] FAIL reset_diff: got %h want 0000", diff); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b want 0", out_ovf); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [15:0] va [11] = '{16'h4200, 16'h3C00, 16'h0002, 16'h3C00, 16'h3C01, 16'h7BFF,
                             16'h7C00, 16'h3C00, 16'h3C00, 16'h8000, 16'h0000};
    logic [15:0] vb [11] = '{16'h3C00, 16'h3C00, 16'h0001, 16'h9000, 16'h9000, 16'hFBFF,
                             16'h7C00, 16'h7C00, 16'h7E01, 16'h0000, 16'h8000};
    logic [15:0] vd [11] = '{16'h4000, 16'h0000, 16'h0001, 16'h3C00, 16'h3C02, 16'h7C00,
                             16'h7E00, 16'hFC00, 16'h7E00, 16'h8000, 16'h0000};
    logic        vo [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int lat;
`ifdef SUBFP16_SAT_EN
    vd[5] = 16'h7BFF;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i];
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin tick(); lat++; end
      total++;
      if (lat != 3) begin bad++; $display("[TB] FAIL latency[%0d]: got %0d want 3", i, lat); end
      total++;
      if ((diff !== vd[i]) || (out_ovf !== vo[i]))
        begin bad++; $display("[TB] FAIL directed[%0d] %h-%h: got %h ovf=%b want %h ovf=%b", i, va[i], vb[i], diff, out_ovf, vd[i], vo[i]); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] pa [8];
    logic [15:0] pb [8];
    logic [16:0] q [$];
    logic [16:0] held, exp;
    logic        held_v;
    int sent, got, stalls, extra;
    sent = 0; got = 0; stalls = 0; extra = 0; held_v = 1'b0; held = '0;
    for (int i = 0; i < 8; i++) begin pa[i] = rand_fp16(); pb[i] = rand_fp16(); end
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid  = (sent < 8);
      a = pa[sent % 8]; b = pb[sent % 8];
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_ready: got %b want 0", in_ready); end
        if (held_v) begin
          total++;
          if ({out_ovf, diff} !== held) begin bad++; $display("[TB] FAIL stall_hold: got %h want %h", {out_ovf, diff}, held); end
        end
        held = {out_ovf, diff}; held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin bad++; $display("[TB] FAIL b2b_extra: got %h want none", diff); end
        else begin
          exp = q.pop_front();
          if ({out_ovf, diff} !== exp) begin bad++; $display("[TB] FAIL b2b[%0d]: got %h want %h", got, {out_ovf, diff}, exp); end
        end
        got++;
      end
      if (in_valid && in_ready) begin q.push_back(ref_sub(a, b)); sent++; end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (stalls == 0) begin bad++; $display("[TB] FAIL b2b_stall_seen: got 0 want >0"); end
    total++; if ((got != 8) || (q.size() != 0)) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 8", got); end
    repeat (6) begin if (out_valid) extra++; tick(); end
    total++; if (extra != 0) begin bad++; $display("[TB] FAIL b2b_dup: got %0d extra want 0", extra); end
  endtask

  task automatic test_random_stream(input int n);
    logic [16:0] q [$];
    logic [16:0] exp;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < n && cyc < 20 * n) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
      a = rand_fp16();
      b = ($urandom_range(0, 3) == 0) ? (a ^ 16'($urandom_range(0, 15))) : rand_fp16();
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin bad++; $display("[TB] FAIL rand_extra: got %h want none", diff); end
        else begin
          exp = q.pop_front();
          if ({out_ovf, diff} !== exp) begin bad++; $display("[TB] FAIL rand[%0d]: got %h want %h", got, {out_ovf, diff}, exp); end
        end
        got++;
      end
      if (in_valid && in_ready) begin q.push_back(ref_sub(a, b)); sent++; end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (got != n) begin bad++; $display("[TB] FAIL rand_timeout: got %0d want %0d", got, n); end
    repeat (4) tick();
  endtask

  task automatic test_reset_midflight();
    int extra, n;
    extra = 0; n = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = rand_fp16(); b = rand_fp16();
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid: got %b want 0", out_valid); end
    total++; if ((diff !== 16'h0000) || (out_ovf !== 1'b0)) begin bad++; $display("[TB] FAIL midrst_out: got %h want 00000", {out_ovf, diff}); end
    repeat (6) begin if (out_valid) extra++; tick(); end
    total++; if (extra != 0) begin bad++; $display("[TB] FAIL midrst_stale: got %0d want 0", extra); end
    in_valid = 1'b1; a = 16'h4200; b = 16'h3C00;
    tick();
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin tick(); n++; end
    total++;
    if ((out_valid !== 1'b1) || (diff !== 16'h4000))
      begin bad++; $display("[TB] FAIL midrst_resume: got v=%b %h want v=1 4000", out_valid, diff); end
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random_stream(300);
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
